// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and reset constants for the fetch-stage PC sequencer.
// Word addresses throughout; byte address = word address << 2.
package pc_pkg;

   localparam logic [31:0] PC_RESET_DEF = 32'h0000_0C00;
   localparam logic [31:0] PC_EXC_DEF   = 32'h0000_1060;

   typedef enum logic {
      RUN,
      PEND
   } pc_state_e;

   typedef enum logic [2:0] {
      SEQ,
      BR,
      J,
      JR,
      EXC,
      ERET
   } redir_src_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Decode/hazard-to-fetch bundle: redirects and stall in, PC out.
// Exception ports exist only when PC_EXC_EN is defined.
interface pc_fetch_if;

   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        j_valid;
   logic [25:0] j_index;
   logic        jr_valid;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus1;
   logic        redirect_pend;
`ifdef PC_EXC_EN
   logic        exc_req;
   logic        eret;
   logic [31:0] epc_in;
   logic [31:0] epc;

   modport master (
      output stall, br_taken, br_target, j_valid, j_index,
      output jr_valid, jr_target, exc_req, eret, epc_in,
      input  pc, pc_plus1, redirect_pend, epc
   );

   modport slave (
      input  stall, br_taken, br_target, j_valid, j_index,
      input  jr_valid, jr_target, exc_req, eret, epc_in,
      output pc, pc_plus1, redirect_pend, epc
   );
`else
   modport master (
      output stall, br_taken, br_target, j_valid, j_index,
      output jr_valid, jr_target,
      input  pc, pc_plus1, redirect_pend
   );

   modport slave (
      input  stall, br_taken, br_target, j_valid, j_index,
      input  jr_valid, jr_target,
      output pc, pc_plus1, redirect_pend
   );
`endif

endinterface

// File: rtl/pc_fetch_unit_next_sel.sv
// Priority select of the decode redirect target (JR > J > BR).
module pc_next_sel
   import pc_pkg::*;
(
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        j_valid_i,
   input  logic [25:0] j_index_i,
   input  logic        jr_valid_i,
   input  logic [31:0] jr_target_i,
   input  logic [5:0]  pc_hi_i,
   output logic [31:0] tgt_o,
   output logic        valid_o
);

   redir_src_e src;

   always_comb begin
      src = SEQ;
      priority case (1'b1)
         jr_valid_i: src = JR;
         j_valid_i:  src = J;
         br_taken_i: src = BR;
         default:    src = SEQ;
      endcase
   end

   always_comb begin
      tgt_o = '0;
      unique case (src)
         JR:      tgt_o = jr_target_i;
         J:       tgt_o = {pc_hi_i, j_index_i};
         BR:      tgt_o = br_target_i;
         default: tgt_o = '0;
      endcase
   end

   assign valid_o = (src != SEQ);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with RUN/PEND redirect buffering across stalls.
// Optional exception entry/return enabled by PC_EXC_EN.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PC_RESET_DEF
`ifdef PC_EXC_EN
   ,
   parameter logic [31:0] EXC_VECTOR = PC_EXC_DEF
`endif
) (
   input  logic       clk,
   input  logic       reset,
   pc_fetch_if.slave  bus
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic        rpend_q;
   logic [31:0] pc_plus1;
   logic [31:0] tgt;
   logic        tgt_vld;

   assign pc_plus1 = pc_q + 32'd1;

   pc_next_sel u_sel (
      .br_taken_i  (bus.br_taken),
      .br_target_i (bus.br_target),
      .j_valid_i   (bus.j_valid),
      .j_index_i   (bus.j_index),
      .jr_valid_i  (bus.jr_valid),
      .jr_target_i (bus.jr_target),
      .pc_hi_i     (pc_plus1[31:26]),
      .tgt_o       (tgt),
      .valid_o     (tgt_vld)
   );

`ifdef PC_EXC_EN
   logic [31:0] epc_q, epc_d;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
`ifdef PC_EXC_EN
      epc_d   = epc_q;
      if (bus.exc_req) begin
         pc_d    = EXC_VECTOR;
         epc_d   = bus.epc_in;
         state_d = RUN;
      end else if (bus.eret) begin
         pc_d    = epc_q;
         state_d = RUN;
      end else
`endif
      begin
         unique case (state_q)
            RUN: begin
               if (!bus.stall) begin
                  pc_d = tgt_vld ? tgt : pc_plus1;
               end else if (tgt_vld) begin
                  pend_d  = tgt;
                  state_d = PEND;
               end
            end
            PEND: begin
               // a redirect seen on the release edge is newer than the buffer
               if (bus.stall) begin
                  if (tgt_vld) pend_d = tgt;
               end else begin
                  pc_d    = tgt_vld ? tgt : pend_q;
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         rpend_q <= 1'b0;
`ifdef PC_EXC_EN
         epc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         rpend_q <= (state_d == PEND);
`ifdef PC_EXC_EN
         epc_q   <= epc_d;
`endif
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_plus1      = pc_plus1;
   assign bus.redirect_pend = rpend_q;
`ifdef PC_EXC_EN
   assign bus.epc           = epc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit; exception cases
// run only when PC_EXC_EN is defined.
module tb_pc_fetch_unit;
   import pc_pkg::*;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   pc_fetch_if bus ();

   pc_fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic [31:0] br_tgt;
      logic        j;
      logic [25:0] j_idx;
      logic        jr;
      logic [31:0] jr_tgt;
      logic [31:0] exp_pc;
      logic [31:0] exp_pp1;
      logic        exp_pend;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic stall,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [25:0] ji,
                      input logic jr, input logic [31:0] jt,
                      input logic [31:0] epc_v, input logic [31:0] epp1,
                      input logic epend);
      vec_t v;
      v.rst = rst; v.stall = stall;
      v.br = br; v.br_tgt = bt;
      v.j = j; v.j_idx = ji;
      v.jr = jr; v.jr_tgt = jt;
      v.exp_pc = epc_v; v.exp_pp1 = epp1; v.exp_pend = epend;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      reset         = 1'b0;
      bus.stall     = 1'b0;
      bus.br_taken  = 1'b0;
      bus.br_target = '0;
      bus.j_valid   = 1'b0;
      bus.j_index   = '0;
      bus.jr_valid  = 1'b0;
      bus.jr_target = '0;
`ifdef PC_EXC_EN
      bus.exc_req   = 1'b0;
      bus.eret      = 1'b0;
      bus.epc_in    = '0;
`endif
   endtask

   initial begin
      errors = 0;
      checks = 0;
      idle();
      reset = 1'b1;

      //   rst st br tgt          j idx          jr tgt          pc            pc+1          pend
      add(1, 0, 0, 0,           0, 0,          0, 0,           32'h0C00,     32'h0C01,     0);
      add(0, 0, 0, 0,           0, 0,          0, 0,           32'h0C01,     32'h0C02,     0);
      add(0, 0, 0, 0,           0, 0,          0, 0,           32'h0C02,     32'h0C03,     0);
      add(0, 0, 0, 0,           0, 0,          0, 0,           32'h0C03,     32'h0C04,     0);
      add(0, 0, 1, 32'h0D00,    0, 0,          0, 0,           32'h0D00,     32'h0D01,     0);
      add(0, 1, 0, 0,           0, 0,          1, 32'h2000,    32'h0D00,     32'h0D01,     1);
      add(0, 1, 0, 0,           0, 0,          0, 0,           32'h0D00,     32'h0D01,     1);
      add(0, 1, 0, 0,           0, 0,          0, 0,           32'h0D00,     32'h0D01,     1);
      add(0, 0, 0, 0,           0, 0,          0, 0,           32'h2000,     32'h2001,     0);
      add(0, 1, 0, 0,           0, 0,          1, 32'h2000,    32'h2000,     32'h2001,     1);
      add(0, 1, 0, 0,           1, 26'h0000123, 0, 0,          32'h2000,     32'h2001,     1);
      add(0, 0, 0, 0,           0, 0,          0, 0,           32'h0000_0123, 32'h0000_0124, 0);
      add(0, 1, 1, 32'h0500,    0, 0,          0, 0,           32'h0123,     32'h0124,     1);
      add(1, 1, 0, 0,           0, 0,          0, 0,           32'h0C00,     32'h0C01,     0);
      add(0, 0, 0, 0,           0, 0,          0, 0,           32'h0C01,     32'h0C02,     0);
      add(0, 0, 1, 32'h0010,    0, 0,          1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,     0);
      add(0, 0, 0, 0,           0, 0,          0, 0,           32'h0,        32'h1,        0);
      add(0, 1, 1, 32'h0040,    0, 0,          0, 0,           32'h0,        32'h1,        1);
      add(0, 0, 0, 0,           1, 26'h3FFFFFF, 0, 0,          32'h03FF_FFFF, 32'h0400_0000, 0);
      add(0, 0, 0, 0,           1, 26'h5,      0, 0,           32'h0400_0005, 32'h0400_0006, 0);
      add(0, 0, 0, 0,           0, 0,          0, 0,           32'h0400_0006, 32'h0400_0007, 0);
      add(0, 1, 0, 0,           0, 0,          0, 0,           32'h0400_0006, 32'h0400_0007, 0);
      add(0, 0, 1, 32'h0099,    1, 26'h7,      0, 0,           32'h0400_0007, 32'h0400_0008, 0);

      foreach (vecs[i]) begin
         reset         = vecs[i].rst;
         bus.stall     = vecs[i].stall;
         bus.br_taken  = vecs[i].br;
         bus.br_target = vecs[i].br_tgt;
         bus.j_valid   = vecs[i].j;
         bus.j_index   = vecs[i].j_idx;
         bus.jr_valid  = vecs[i].jr;
         bus.jr_target = vecs[i].jr_tgt;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d pc", i), bus.pc, vecs[i].exp_pc);
         chk($sformatf("v%0d pc_plus1", i), bus.pc_plus1, vecs[i].exp_pp1);
         chk($sformatf("v%0d pend", i), {31'b0, bus.redirect_pend},
             {31'b0, vecs[i].exp_pend});
      end

      // reset held while every redirect is asserted
      idle();
      reset         = 1'b1;
      bus.stall     = 1'b1;
      bus.jr_valid  = 1'b1;
      bus.jr_target = 32'h7777;
      bus.br_taken  = 1'b1;
      @(posedge clk); #1;
      bus.stall = 1'b0;
      @(posedge clk); #1;
      chk("rst_over pc", bus.pc, 32'h0C00);
      chk("rst_over pend", {31'b0, bus.redirect_pend}, 32'h0);
      idle();
      @(posedge clk); #1;
      chk("rst_after pc", bus.pc, 32'h0C01);

`ifdef PC_EXC_EN
      idle();
      bus.stall     = 1'b1;
      bus.jr_valid  = 1'b1;
      bus.jr_target = 32'h3000;
      @(posedge clk); #1;
      chk("exc_pre pend", {31'b0, bus.redirect_pend}, 32'h1);
      bus.jr_valid = 1'b0;
      bus.exc_req  = 1'b1;
      bus.epc_in   = 32'h0C05;
      @(posedge clk); #1;
      chk("exc pc", bus.pc, 32'h1060);
      chk("exc epc", bus.epc, 32'h0C05);
      chk("exc pend", {31'b0, bus.redirect_pend}, 32'h0);
      bus.exc_req = 1'b0;
      bus.epc_in  = 32'h0;
      bus.eret    = 1'b1;
      @(posedge clk); #1;
      chk("eret pc", bus.pc, 32'h0C05);
      bus.exc_req = 1'b1;
      bus.epc_in  = 32'h0ABC;
      @(posedge clk); #1;
      chk("exc_eret pc", bus.pc, 32'h1060);
      chk("exc_eret epc", bus.epc, 32'h0ABC);
      idle();
      @(posedge clk); #1;
      chk("exc_run pc", bus.pc, 32'h1061);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and next-PC sequencer for the fetch stage of the pipelined CPU. Holds the word-addressed fetch PC, drives the incremented PC, and consumes redirect requests (branch, jump, jump-register) from decode. Redirects that arrive while fetch is stalled are buffered and applied when the stall releases.

## Interface
Parameters:
- RESET_PC, 32'h0000_0C00: word address loaded on reset (byte 0x0000_3000).
- EXC_VECTOR, 32'h0000_1060: word address of the exception handler (byte 0x0000_4180); used only with PC_EXC_EN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit holds fetch; PC must not advance.
- br_taken  in  1  decode-resolved taken branch.
- br_target  in  32  branch word address.
- j_valid  in  1  J/JAL in decode.
- j_index  in  26  instruction index field.
- jr_valid  in  1  JR/JALR in decode.
- jr_target  in  32  register-sourced word address.
- pc  out  32  current fetch word address.
- pc_plus1  out  32  pc + 1, modulo 2^32.
- redirect_pend  out  1  a buffered redirect awaits stall release.
- exc_req, eret  in  1 each; epc_in  in  32; epc  out  32 (only with PC_EXC_EN).

## Operation
- State machine, two states: RUN (no buffered redirect), PEND (target latched in pend_target).
- Redirect source this cycle, priority high to low: jr_valid > j_valid > br_taken. At most one is expected; priority resolves overlap.
- J target = {pc_plus1[31:26], j_index}.
- RUN, stall=0: pc <= redirect target if any, else pc_plus1.
- RUN, stall=1, no redirect: pc holds.
- RUN, stall=1, redirect: pc holds; pend_target <= target; go PEND.
- PEND, stall=1: pc holds; a new redirect overwrites pend_target (last wins).
- PEND, stall=0: pc <= (new redirect this cycle ? its target : pend_target); go RUN.
- redirect_pend = (state == PEND), registered.
- pc_plus1 combinational from pc; wraps 32'hFFFF_FFFF -> 0.
- Reset: pc = RESET_PC, state = RUN, pend_target = 0, redirect_pend = 0, epc = 0; reset overrides every other input in the same cycle.

## Timing
- One-cycle redirect latency: redirect sampled at edge N is the pc value after edge N (stall=0).
- Stall has zero latency: stall high at edge N means pc after N equals pc before N.
- Buffered redirect applies at the first edge with stall=0; no extra cycle is added.
- No combinational path from any input to pc or redirect_pend; pc_plus1 depends only on pc.

## Configuration
- PC_EXC_EN defined: exc_req, eret, epc_in, epc present. exc_req (highest priority after reset, ignores stall) loads pc <= EXC_VECTOR, epc <= epc_in, clears PEND to RUN. eret (next priority, ignores stall) loads pc <= epc, clears PEND. exc_req and eret together: exc_req wins.
- PC_EXC_EN undefined: those ports and epc register do not exist; behaviour is exactly the RUN/PEND machine above.

## Structure
- Shared package pc_pkg: RESET_PC and EXC_VECTOR defaults, state enum (RUN, PEND), redirect-source enum (SEQ, BR, J, JR, EXC, ERET).
- One sub-module: pc_next_sel, combinational priority select producing target and valid from redirect inputs and pc_plus1.

## Test plan
- Reset then 4 free-running cycles -> pc = 0x0C00, 0x0C01, 0x0C02, 0x0C03; redirect_pend = 0.
- br_taken=1, br_target=0x0D00 with stall=0 -> pc = 0x0D00 next cycle; pc_plus1 = 0x0D01.
- stall=1 for 3 cycles, jr_valid pulse (target 0x2000) in cycle 1 -> pc held, redirect_pend = 1 for cycles 2–3; stall drops -> pc = 0x2000, redirect_pend = 0.
- PEND with 0x2000, j_valid index 0x0000123 while still stalled -> release yields pc = {upper6, 0x0000123}; reset asserted during PEND -> pc = 0x0C00, redirect_pend = 0.
- pc forced to 0xFFFF_FFFF via jr -> pc_plus1 = 0, next free-run pc = 0.
- PC_EXC_EN: exc_req with stall=1, epc_in=0x0C05 -> pc = 0x1060, epc = 0x0C05; eret -> pc = 0x0C05.
